// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a host/loader port, with a read-return tag pipe.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int unsigned DW           = 32,
    parameter int unsigned AW           = 32,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]   perf_cpu_stall_cnt,
    output logic [31:0]   perf_host_beats,
    output logic [15:0]   perf_forced_gnt,
`endif
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned LW = RD_LAT;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ARB_CPU  = 1'b0,
        ARB_HOST = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_burst_cnt;
    logic [BW-1:0] w_burst_nxt;
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_nxt;
    logic          w_cpu_gnt;
    logic          w_host_gnt;
    logic          w_starved;

    logic [LW-1:0] r_tag_vld;
    logic [LW-1:0] r_tag_own;
    logic [LW-1:0] w_tag_vld_in;
    logic [LW-1:0] w_tag_own_in;
    logic          w_tail_in_vld;
    logic          w_tail_in_own;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_host_rdata;

    assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));

    // Grant and next-state; grants are suppressed while reset is asserted so every output reads 0.
    always_comb begin
        w_cpu_gnt   = 1'b0;
        w_host_gnt  = 1'b0;
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        if (rst) begin
            case (r_state)
                ARB_CPU: begin
                    if (host_req && (w_starved || !cpu_req)) begin
                        w_host_gnt = 1'b1;
                    end else begin
                        w_cpu_gnt = cpu_req;
                    end
                    if (w_host_gnt && host_lock) begin
                        w_state_nxt = ARB_HOST;
                        w_burst_nxt = BW'(1);
                    end
                end
                ARB_HOST: begin
                    if (!host_req) begin
                        w_cpu_gnt   = cpu_req;
                        w_state_nxt = ARB_CPU;
                        w_burst_nxt = '0;
                    end else if (cpu_req && (r_burst_cnt == BW'(MAX_BURST))) begin
                        w_cpu_gnt   = 1'b1;
                        w_state_nxt = ARB_CPU;
                        w_burst_nxt = '0;
                    end else begin
                        w_host_gnt = 1'b1;
                        if (cpu_req) begin
                            w_burst_nxt = r_burst_cnt + BW'(1);
                        end
                        if (!host_lock) begin
                            w_state_nxt = ARB_CPU;
                            w_burst_nxt = '0;
                        end
                    end
                end
                default: w_state_nxt = ARB_CPU;
            endcase
        end
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!host_req || w_host_gnt) begin
            w_starve_nxt = '0;
        end else if (!w_starved) begin
            w_starve_nxt = r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARB_CPU;
            r_burst_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    assign mem_addr  = w_host_gnt ? host_addr  : (w_cpu_gnt ? cpu_addr  : '0);
    assign mem_wdata = w_host_gnt ? host_wdata : (w_cpu_gnt ? cpu_wdata : '0);
    assign mem_re    = (w_cpu_gnt & ~cpu_we) | (w_host_gnt & ~host_we);
    assign mem_we    = (w_cpu_gnt & cpu_we)  | (w_host_gnt & host_we);
    assign cpu_stall = rst & cpu_req & ~w_cpu_gnt;
    assign host_gnt  = w_host_gnt;

    // mem_rdata is captured on the RD_LAT-th edge after issue, as the tag enters the tail stage.
    assign w_tag_vld_in  = LW'({r_tag_vld, mem_re});
    assign w_tag_own_in  = LW'({r_tag_own, w_host_gnt});
    assign w_tail_in_vld = w_tag_vld_in[LW-1];
    assign w_tail_in_own = w_tag_own_in[LW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld    <= '0;
            r_tag_own    <= '0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            r_tag_vld <= w_tag_vld_in;
            r_tag_own <= w_tag_own_in;
            if (w_tail_in_vld && !w_tail_in_own) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (w_tail_in_vld && w_tail_in_own) begin
                r_host_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid  = r_tag_vld[LW-1] & ~r_tag_own[LW-1];
    assign host_rvalid = r_tag_vld[LW-1] & r_tag_own[LW-1];
    assign cpu_rdata   = r_cpu_rdata;
    assign host_rdata  = r_host_rdata;

`ifdef DMEM_ARB_PERF_EN
    logic        w_forced;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_beats;
    logic [15:0] r_perf_forced;

    // A host grant in ARB_CPU while the CPU is requesting can only come from starvation.
    assign w_forced = (r_state == ARB_CPU) & w_host_gnt & cpu_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall  <= '0;
            r_perf_beats  <= '0;
            r_perf_forced <= '0;
        end else begin
            r_perf_stall  <= r_perf_stall + 32'(cpu_stall);
            r_perf_beats  <= r_perf_beats + 32'(w_host_gnt);
            r_perf_forced <= r_perf_forced + 16'(w_forced);
        end
    end

    assign perf_cpu_stall_cnt = r_perf_stall;
    assign perf_host_beats    = r_perf_beats;
    assign perf_forced_gnt    = r_perf_forced;
`endif

endmodule
